// File: rtl/dffram_nibble_master.sv
// Byte-wide master for a nibble-wide dual-port DFF RAM tile: configures the tile, then
// splits byte writes/reads into two nibble phases and returns one response per request.
module dffram_nibble_master #(
    parameter int unsigned RD_BUF     = 0,
    parameter int unsigned CFG_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_port,
    input  logic [4:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] ram_ui_in,
    output logic [7:0] ram_uio_in,
    input  logic [7:0] ram_uo_out,
    output logic       ram_rst_n
);

    typedef enum logic [2:0] {
        StCfg, StHold, StIdle, StWrLo, StWrHi, StRdLo, StRdHi, StRsp
    } state_e;

    localparam logic            RdBufBit = (RD_BUF != 0);
    localparam int unsigned     CntW     = (CFG_CYCLES > 1) ? $clog2(CFG_CYCLES) : 1;
    localparam logic [CntW-1:0] CfgLast  = CntW'(CFG_CYCLES - 1);

    state_e          state_q;
    logic            bank_q, pend_q, wr_q, port_q, err_q, wait_q;
    logic [3:0]      addr_q;
    logic [7:0]      wdata_q, data_q;
    logic [CntW-1:0] cnt_q;

    logic       in_idle, accept, addr_err, start_op, op_write, op_port;
    logic [3:0] op_addr, op_wlo, rd_nib;

    // Tile config word: {w_en, write_through, read_buffer_b, read_buffer_a, 000, bank}
    function automatic logic [7:0] cfg_bus(input logic bank);
        return {2'b00, RdBufBit, RdBufBit, 3'b000, bank};
    endfunction

    // A deferred op (after a bank switch) starts from HOLD using the latched fields.
    assign in_idle  = (state_q == StIdle);
    assign accept   = in_idle && req_valid;
    assign addr_err = (req_addr >= 5'd24);
    assign start_op = (accept && !addr_err && (req_addr[4] == bank_q)) ||
                      ((state_q == StHold) && pend_q);
    assign op_write = in_idle ? req_write : wr_q;
    assign op_port  = in_idle ? req_port : port_q;
    assign op_addr  = in_idle ? req_addr[3:0] : addr_q;
    assign op_wlo   = in_idle ? req_wdata[3:0] : wdata_q[3:0];
    assign rd_nib   = port_q ? ram_uo_out[7:4] : ram_uo_out[3:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StCfg;
            bank_q     <= 1'b0;
            pend_q     <= 1'b0;
            wr_q       <= 1'b0;
            port_q     <= 1'b0;
            err_q      <= 1'b0;
            wait_q     <= 1'b0;
            addr_q     <= 4'h0;
            wdata_q    <= 8'h00;
            data_q     <= 8'h00;
            cnt_q      <= CfgLast;
            ram_rst_n  <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 8'h00;
            rsp_err    <= 1'b0;
            ram_ui_in  <= 8'h00;
            ram_uio_in <= cfg_bus(1'b0);
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                wr_q    <= req_write;
                port_q  <= req_port;
                addr_q  <= req_addr[3:0];
                wdata_q <= req_wdata;
                err_q   <= addr_err;
            end
            if (start_op) begin
                req_ready <= 1'b0;
                pend_q    <= 1'b0;
                if (op_write) begin
                    state_q       <= StWrLo;
                    ram_ui_in     <= {op_addr, op_wlo};
                    ram_uio_in[7] <= 1'b1;
                    ram_uio_in[4] <= 1'b1;
                end else begin
                    state_q <= StRdLo;
                    wait_q  <= RdBufBit;
                    if (op_port) begin
                        ram_uio_in[3:0] <= op_addr;
                        ram_uio_in[5]   <= 1'b0;
                    end else begin
                        ram_ui_in[7:4] <= op_addr;
                        ram_uio_in[4]  <= 1'b0;
                    end
                end
            end else begin
                case (state_q)
                    StCfg: begin
                        if (cnt_q == '0) begin
                            state_q   <= StHold;
                            ram_rst_n <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CntW'(1);
                        end
                    end
                    StHold: begin
                        state_q   <= StIdle;
                        req_ready <= 1'b1;
                    end
                    StIdle: begin
                        if (req_valid) begin
                            req_ready <= 1'b0;
                            if (addr_err) begin
                                state_q <= StRsp;
                            end else begin
                                // Bank mismatch: reprogram the tile, then run the op.
                                state_q    <= StCfg;
                                bank_q     <= req_addr[4];
                                pend_q     <= 1'b1;
                                cnt_q      <= CfgLast;
                                ram_rst_n  <= 1'b0;
                                ram_uio_in <= cfg_bus(req_addr[4]);
                            end
                        end
                    end
                    StWrLo: begin
                        state_q        <= StWrHi;
                        ram_ui_in[3:0] <= wdata_q[7:4];
                        ram_uio_in[4]  <= 1'b0;
                    end
                    StWrHi: begin
                        state_q       <= StRsp;
                        ram_uio_in[7] <= 1'b0;
                    end
                    StRdLo: begin
                        if (wait_q) begin
                            wait_q <= 1'b0;
                        end else begin
                            state_q     <= StRdHi;
                            data_q[3:0] <= rd_nib;
                            wait_q      <= RdBufBit;
                            if (port_q) ram_uio_in[5] <= 1'b1;
                            else        ram_uio_in[4] <= 1'b1;
                        end
                    end
                    StRdHi: begin
                        if (wait_q) begin
                            wait_q <= 1'b0;
                        end else begin
                            state_q     <= StRsp;
                            data_q[7:4] <= rd_nib;
                        end
                    end
                    StRsp: begin
                        state_q   <= StIdle;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        rsp_rdata <= (err_q || wr_q) ? 8'h00 : data_q;
                    end
                    default: state_q <= StCfg;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dffram_nibble_master.sv
// Bench for dffram_nibble_master: an unbuffered and a buffered instance, each on a behavioural
// nibble RAM tile, with a response scoreboard and byte reference model.
module tb_dffram_nibble_master;

    typedef struct {
        int         acc;
        int         lat;
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_write [2];
    logic       req_port  [2];
    logic [4:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic       rsp_err   [2];
    logic [7:0] ram_ui_in [2];
    logic [7:0] ram_uio_in[2];
    logic [7:0] ram_uo_out[2];
    logic       ram_rst_n [2];

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    exp_t       sb0[$];
    exp_t       sb1[$];
    logic [8:0] wen_log[$];
    int         rlow_cnt = 0;
    int         rlow_hi = 0;
    logic [7:0] ref_mem[2][32];
    logic       bank_m[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [3:0] mem[2][16][2];
        logic       cfg_bank;
        logic [7:0] uo_comb, uo_q;

        dffram_nibble_master #(.RD_BUF(g), .CFG_CYCLES(2)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_port  (req_port[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .ram_ui_in (ram_ui_in[g]),
            .ram_uio_in(ram_uio_in[g]),
            .ram_uo_out(ram_uo_out[g]),
            .ram_rst_n (ram_rst_n[g])
        );

        // Tile: config latched while ram_rst_n is low; a write with lohi_a=1 stores the low half.
        always @(posedge clk) begin
            if (!ram_rst_n[g]) cfg_bank <= ram_uio_in[g][0];
            else if (ram_uio_in[g][7])
                mem[cfg_bank][ram_ui_in[g][7:4]][!ram_uio_in[g][4]] <= ram_ui_in[g][3:0];
            uo_q <= uo_comb;
        end
        assign uo_comb = {mem[cfg_bank][ram_uio_in[g][3:0]][ram_uio_in[g][5]],
                          mem[cfg_bank][ram_ui_in[g][7:4]][ram_uio_in[g][4]]};
        assign ram_uo_out[g] = (g == 1) ? uo_q : uo_comb;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sb_size(input int i);
        return (i == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic pop_check(input int i);
        exp_t e;
        int   sz;
        sz = sb_size(i);
        check_eq($sformatf("rsp%0d_expected", i), (sz > 0), 1);
        if (sz == 0) return;
        e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
        check_eq($sformatf("rsp%0d_data", i), rsp_rdata[i], e.data);
        check_eq($sformatf("rsp%0d_err", i), rsp_err[i], e.err);
        check_eq($sformatf("rsp%0d_latency", i), cyc - e.acc, e.lat);
    endtask

    always @(negedge clk) if (rsp_valid[0]) pop_check(0);
    always @(negedge clk) if (rsp_valid[1]) pop_check(1);

    always @(negedge clk) begin
        if (ram_uio_in[0][7]) wen_log.push_back({ram_uio_in[0][4], ram_ui_in[0]});
        if (rst_n && !ram_rst_n[0]) begin
            rlow_cnt++;
            if (ram_uio_in[0][0]) rlow_hi++;
        end
    end

    task automatic do_req(input int i, input logic wr, input logic port, input logic [4:0] addr,
                          input logic [7:0] wdata);
        exp_t e;
        int   n;
        e.err  = (addr >= 5'd24);
        e.data = (e.err || wr) ? 8'h00 : ref_mem[i][addr];
        e.lat  = 1;
        if (!e.err) begin
            e.lat = (!wr && i == 1) ? 5 : 3;
            if (addr[4] != bank_m[i]) begin
                e.lat += 3;
                bank_m[i] = addr[4];
            end
            if (wr) ref_mem[i][addr] = wdata;
        end
        @(negedge clk);
        req_write[i] = wr;
        req_port[i]  = port;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_valid[i] = 1'b1;
        n = 0;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("req%0d_ready", i), req_ready[i], 1);
        if (!req_ready[i]) begin
            req_valid[i] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.acc = cyc;
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        // Scramble the request bus: the DUT must work from its latched copy.
        req_valid[i] = 1'b0;
        req_write[i] = !wr;
        req_port[i]  = !port;
        req_addr[i]  = ~addr;
        req_wdata[i] = ~wdata;
        n = 0;
        while (sb_size(i) != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq($sformatf("req%0d_drain", i), sb_size(i), 0);
    endtask

    task automatic check_cfg_seq(input string tag);
        @(negedge clk);
        check_eq({tag, "_cfg_rstn"}, ram_rst_n[0], 0);
        check_eq({tag, "_cfg_ready"}, req_ready[0], 0);
        @(negedge clk);
        check_eq({tag, "_hold_rstn"}, ram_rst_n[0], 1);
        check_eq({tag, "_hold_ready"}, req_ready[0], 0);
        check_eq({tag, "_hold_cfg1"}, ram_uio_in[1], 8'h30);
        @(negedge clk);
        check_eq({tag, "_idle_ready0"}, req_ready[0], 1);
        check_eq({tag, "_idle_ready1"}, req_ready[1], 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         rc;
        int         rh;
        int         n;
        logic [7:0] ui_before;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_port[i]  = 1'b0;
            req_addr[i]  = 5'h00;
            req_wdata[i] = 8'h00;
            bank_m[i]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_eq("rst_ram_rstn", ram_rst_n[0], 0);
        check_eq("rst_ready", req_ready[0], 0);
        check_eq("rst_rsp_valid", rsp_valid[0], 0);
        check_eq("rst_rdata", rsp_rdata[0], 0);
        check_eq("rst_err", rsp_err[0], 0);
        check_eq("rst_ui", ram_ui_in[0], 0);
        check_eq("rst_uio0", ram_uio_in[0], 8'h00);
        check_eq("rst_uio1", ram_uio_in[1], 8'h30);
        rst_n = 1'b1;
        check_cfg_seq("por");

        base = wen_log.size();
        do_req(0, 1'b1, 1'b0, 5'h03, 8'h5A);
        check_eq("wen_count", wen_log.size() - base, 2);
        if (wen_log.size() >= base + 2) begin
            check_eq("wen_lo", wen_log[base], {1'b1, 4'h3, 4'hA});
            check_eq("wen_hi", wen_log[base + 1], {1'b0, 4'h3, 4'h5});
        end
        do_req(0, 1'b0, 1'b0, 5'h03, 8'h00);

        do_req(0, 1'b1, 1'b0, 5'h07, 8'hC3);
        ui_before = ram_ui_in[0];
        do_req(0, 1'b0, 1'b1, 5'h07, 8'h00);
        check_eq("portb_ui_kept", ram_ui_in[0], ui_before);

        do_req(0, 1'b1, 1'b0, 5'h12, 8'h96);
        do_req(0, 1'b0, 1'b0, 5'h03, 8'h00);
        rc = rlow_cnt;
        rh = rlow_hi;
        do_req(0, 1'b0, 1'b0, 5'h12, 8'h00);
        check_eq("bank1_rstn_low", rlow_cnt - rc, 2);
        check_eq("bank1_cfg_bit", rlow_hi - rh, 2);

        base = wen_log.size();
        do_req(0, 1'b1, 1'b0, 5'h19, 8'hEE);
        check_eq("err_no_wen", wen_log.size() - base, 0);
        do_req(0, 1'b0, 1'b0, 5'h18, 8'h00);
        do_req(0, 1'b1, 1'b0, 5'h17, 8'h3C);
        do_req(0, 1'b0, 1'b1, 5'h17, 8'h00);

        do_req(1, 1'b1, 1'b0, 5'h03, 8'h5A);
        do_req(1, 1'b0, 1'b0, 5'h03, 8'h00);
        do_req(1, 1'b1, 1'b0, 5'h13, 8'hE1);
        do_req(1, 1'b0, 1'b1, 5'h13, 8'h00);

        // Reset while the high nibble of a write is on the bus.
        @(negedge clk);
        req_write[0] = 1'b1;
        req_port[0]  = 1'b0;
        req_addr[0]  = 5'h05;
        req_wdata[0] = 8'hFF;
        req_valid[0] = 1'b1;
        n = 0;
        while (!req_ready[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_ready", req_ready[0], 1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        n = 0;
        while (!(ram_uio_in[0][7] && !ram_uio_in[0][4]) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_in_wr_hi", {ram_uio_in[0][7], ram_uio_in[0][4]}, 2'b10);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_wen_off", ram_uio_in[0][7], 0);
        check_eq("mid_ram_rstn", ram_rst_n[0], 0);
        check_eq("mid_no_rsp", rsp_valid[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        bank_m[0] = 1'b0;
        bank_m[1] = 1'b0;
        check_cfg_seq("mid");
        repeat (5) @(negedge clk);
        check_eq("end_sb0_empty", sb0.size(), 0);
        check_eq("end_sb1_empty", sb1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dffram_nibble_master.md
DFFRAM_NIBBLE_MASTER -- requirements
Module: dffram_nibble_master

Interface
REQ-001 SHALL have parameter RD_BUF, default 0, meaning the read_buffer_a/b value programmed into the RAM tile (0 = unbuffered, 1 = buffered).
REQ-002 SHALL have parameter CFG_CYCLES, default 2, meaning the number of cycles ram_rst_n is held low per configuration.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, request accepted when high with req_valid at the same edge.
REQ-007 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port req_port, input, 1, read port select (0 = A, 1 = B); ignored for writes, which always use port A.
REQ-009 SHALL have port req_addr, input, 5, byte address; bit 4 selects the bank.
REQ-010 SHALL have port req_wdata, input, 8, write byte.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, 8, read byte; 0 for writes and errors.
REQ-013 SHALL have port rsp_err, output, 1, out-of-range address flag.
REQ-014 SHALL have port ram_ui_in, output, 8, driven to the tile ui_in: [3:0] wdata_a, [7:4] addr_a.
REQ-015 SHALL have port ram_uio_in, output, 8, driven to the tile uio_in: [3:0] addr_b or config, [4] lohi_a, [5] lohi_b, [7] w_en.
REQ-016 SHALL have port ram_uo_out, input, 8, from the tile: [3:0] rdata_a, [7:4] rdata_b.
REQ-017 SHALL have port ram_rst_n, output, 1, tile reset and configuration strobe.

Function
REQ-018 SHALL register all outputs; the tile is assumed to see new pin values right after each clk edge.
REQ-019 SHALL implement states CFG, HOLD, IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RSP.
REQ-020 SHALL, in CFG, drive ram_rst_n=0 for CFG_CYCLES cycles with ram_uio_in = {0, 0, RD_BUF, RD_BUF, 000, bank}; w_en and write_through are always 0.
REQ-021 SHALL, in HOLD (one cycle), drive ram_rst_n=1 with the configuration bits unchanged, so the tile latch closes before the bus changes.
REQ-022 SHALL assert req_ready only in IDLE.
REQ-023 SHALL, on acceptance with req_addr >= 24 (aliased region), skip RAM activity and go to RSP with rsp_err=1 and rsp_rdata=0.
REQ-024 SHALL, on acceptance with req_addr[4] != bank, update bank and pass through CFG and HOLD before executing the operation; storage is not cleared.
REQ-025 SHALL, in WR_LO, drive addr_a=req_addr[3:0], wdata_a=wdata[3:0], lohi_a=1, w_en=1; in WR_HI, drive wdata_a=wdata[7:4], lohi_a=0, w_en=1.
REQ-026 SHALL drive w_en=0 in every state other than WR_LO and WR_HI.
REQ-027 SHALL, in RD_LO, drive lohi=0 on the selected port and the address on addr_a or addr_b; in RD_HI, drive lohi=1.
REQ-028 SHALL sample the nibble from ram_uo_out[3:0] (port A) or [7:4] (port B) at the last edge of each read phase.
REQ-029 SHALL make each read phase last 1 cycle if RD_BUF=0 and 2 cycles if RD_BUF=1, using an internal wait counter.
REQ-030 SHALL, in RSP, pulse rsp_valid for exactly one cycle, then return to IDLE.
REQ-031 SHALL hold rsp_rdata and rsp_err until the next RSP.
REQ-032 SHALL make rsp_valid occur 3 cycles after the acceptance edge for an in-bank write or an unbuffered read, 5 cycles for a buffered read, and 1 cycle for an error.
REQ-033 SHALL latch request fields at acceptance; later req_* changes are ignored.

Reset
REQ-034 SHALL, while rst_n=0, set state=CFG, bank=0, ram_rst_n=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and ram_ui_in=0.
REQ-035 SHALL, after rst_n rises, complete CFG_CYCLES cycles of CFG and then HOLD before reaching IDLE.
REQ-036 SHALL, when reset is asserted mid-operation, abort the operation within one cycle and drive w_en=0; no response is produced.

Verification
REQ-037 Write 0x5A to 0x03, then read port A, RD_BUF=0 -> two write cycles (lohi_a 1 then 0); read response 0x5A with rsp_err=0.
REQ-038 Write 0xC3 to 0x07, then read port B -> rdata_b nibbles assembled to 0xC3; the read does not disturb port A.
REQ-039 Read 0x12 while bank=0 -> ram_rst_n low 2 cycles with uio[0]=1, then HOLD, then read; 0x03 still holds 0x5A afterward.
REQ-040 Request to address 0x19 -> rsp_err=1 one cycle after acceptance; w_en never asserts.
REQ-041 RD_BUF=1, read 0x03 -> rsp_valid 5 cycles after acceptance with data 0x5A.
REQ-042 Assert rst_n=0 during WR_HI -> w_en=0 on the next edge and no rsp_valid; full CFG sequence follows release.
